// File: rtl/multicycle_control_fsm_pkg.sv
// Purpose : shared types and encodings for the multi-cycle CPU control unit.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
// Contents: state enum, opcode constants, ALU op codes, datapath mux selects,
//           opcode class struct and the packed control-strobe bundle.
package multicycle_control_fsm_pkg;

    typedef enum logic [3:0] {
        ST_RST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_ALU_WB,
        ST_ADDR,
        ST_MEM_RD,
        ST_MEM_WB,
        ST_MEM_WR,
        ST_BRANCH,
        ST_JUMP,
        ST_HALT
    } state_e;

    localparam logic [4:0] OP_NOP  = 5'h00;
    localparam logic [4:0] OP_ADDI = 5'h08;
    localparam logic [4:0] OP_ANDI = 5'h09;
    localparam logic [4:0] OP_ORI  = 5'h0A;
    localparam logic [4:0] OP_LD   = 5'h10;
    localparam logic [4:0] OP_ST   = 5'h11;
    localparam logic [4:0] OP_BEQ  = 5'h18;
    localparam logic [4:0] OP_BNE  = 5'h19;
    localparam logic [4:0] OP_JMP  = 5'h1C;
    localparam logic [4:0] OP_HALT = 5'h1F;

    localparam logic [3:0] ALU_NONE = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;

    localparam logic       SRC_A_PC  = 1'b0;
    localparam logic       SRC_A_REG = 1'b1;
    localparam logic [1:0] SRC_B_REG = 2'd0;
    localparam logic [1:0] SRC_B_ONE = 2'd1;
    localparam logic [1:0] SRC_B_IMM = 2'd2;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    // Exactly one class bit is set for any opcode (is_bne rides along with is_br).
    typedef struct packed {
        logic is_r;
        logic is_i;
        logic is_ld;
        logic is_st;
        logic is_br;
        logic is_bne;
        logic is_jmp;
        logic is_nop;
        logic is_halt;
        logic is_illegal;
    } op_class_t;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic [1:0] pc_source;
        logic       halted;
    } ctrl_t;

    // States that talk to memory and therefore wait on mem_ready.
    function automatic logic is_mem_state(input state_e s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Purpose : control-unit <-> datapath signal bundle.
// Latency : n/a (wires only).
// Backpr. : mem_ready is the only flow control; the control unit stalls on it.
// master  : control unit (consumes opcode/zero/mem_ready, drives strobes/status).
// slave   : datapath/memory side.
interface multicycle_control_fsm_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             ir_write;
    logic             pc_write;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic             mem_to_reg;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [3:0]       alu_op;
    logic [1:0]       pc_source;
    logic             halted;
    logic             illegal_op;
    logic             bus_error;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, zero, mem_ready,
        output ir_write, pc_write, i_or_d, mem_read, mem_write, reg_write,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
               halted, illegal_op, bus_error, retired
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  ir_write, pc_write, i_or_d, mem_read, mem_write, reg_write,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
               halted, illegal_op, bus_error, retired
    );
endinterface

// File: rtl/multicycle_control_fsm_opcode_classifier.sv
// Purpose : classify the 5-bit opcode and pick its ALU operation.
// Latency : combinational.
// Backpr. : none.
// Ports   : opcode_i (IR[28:24]) -> cls_o (one-hot class), alu_op_o (EXEC op).
module multicycle_control_fsm_opcode_classifier
    import multicycle_control_fsm_pkg::*;
(
    input  logic [4:0] opcode_i,
    output op_class_t  cls_o,
    output logic [3:0] alu_op_o
);

    always_comb begin
        cls_o    = '0;
        alu_op_o = ALU_ADD;
        case (opcode_i)
            OP_NOP:  cls_o.is_nop = 1'b1;
            5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07: begin
                // R-type opcodes are numbered to match the ALU op encoding.
                cls_o.is_r = 1'b1;
                alu_op_o   = opcode_i[3:0];
            end
            OP_ADDI: begin cls_o.is_i = 1'b1; alu_op_o = ALU_ADD; end
            OP_ANDI: begin cls_o.is_i = 1'b1; alu_op_o = ALU_AND; end
            OP_ORI:  begin cls_o.is_i = 1'b1; alu_op_o = ALU_OR;  end
            OP_LD:   cls_o.is_ld   = 1'b1;
            OP_ST:   cls_o.is_st   = 1'b1;
            OP_BEQ:  cls_o.is_br   = 1'b1;
            OP_BNE:  begin cls_o.is_br = 1'b1; cls_o.is_bne = 1'b1; end
            OP_JMP:  cls_o.is_jmp  = 1'b1;
            OP_HALT: cls_o.is_halt = 1'b1;
            default: cls_o.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Purpose : multi-cycle CPU control FSM with memory wait states, bus timeout,
//           sticky halt/illegal/bus-error status and a retired-instruction counter.
// Latency : 2 (NOP) / 3 (JMP, BEQ, BNE) / 4 (R, I, ST) / 5 (LD) cycles at mem_ready=1.
// Backpr. : FETCH/MEM_RD/MEM_WR hold until mem_ready; MEM_TIMEOUT idle cycles -> bus_error, HALT.
// Ports   : clk, reset_n (async active-low), bus (master side of multicycle_control_fsm_if).
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    multicycle_control_fsm_if.master   bus
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             illegal_q, illegal_d;
    logic             bus_err_q, bus_err_d;

    op_class_t  cls;
    logic [3:0] cls_alu_op;
    ctrl_t      ctrl;
    logic       retire;
    logic       timeout;

    multicycle_control_fsm_opcode_classifier u_classifier (
        .opcode_i (bus.opcode),
        .cls_o    (cls),
        .alu_op_o (cls_alu_op)
    );

    // The current cycle is the MEM_TIMEOUT-th without mem_ready; a ready
    // arriving in that same cycle still wins.
    assign timeout = !bus.mem_ready && (wait_q == WAIT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_RST_IDLE;
            wait_q    <= '0;
            retired_q <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        retire    = 1'b0;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        case (state_q)
            ST_RST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (bus.mem_ready) begin
                    state_d = ST_DECODE;
                end else if (timeout) begin
                    state_d   = ST_HALT;
                    bus_err_d = 1'b1;
                end
            end
            ST_DECODE: begin
                if (cls.is_r || cls.is_i) begin
                    state_d = ST_EXEC;
                end else if (cls.is_ld || cls.is_st) begin
                    state_d = ST_ADDR;
                end else if (cls.is_br) begin
                    state_d = ST_BRANCH;
                end else if (cls.is_jmp) begin
                    state_d = ST_JUMP;
                end else if (cls.is_halt) begin
                    state_d = ST_HALT;
                end else if (cls.is_nop || cls.is_illegal) begin
                    // Illegal opcodes retire as NOPs but leave a sticky flag.
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                    if (cls.is_illegal) begin
                        illegal_d = 1'b1;
                    end
                end
            end
            ST_EXEC:   state_d = ST_ALU_WB;
            ST_ALU_WB: begin state_d = ST_FETCH; retire = 1'b1; end
            ST_ADDR:   state_d = cls.is_ld ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD: begin
                if (bus.mem_ready) begin
                    state_d = ST_MEM_WB;
                end else if (timeout) begin
                    state_d   = ST_HALT;
                    bus_err_d = 1'b1;
                end
            end
            ST_MEM_WB: begin state_d = ST_FETCH; retire = 1'b1; end
            ST_MEM_WR: begin
                if (bus.mem_ready) begin
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end else if (timeout) begin
                    state_d   = ST_HALT;
                    bus_err_d = 1'b1;
                end
            end
            ST_BRANCH: begin state_d = ST_FETCH; retire = 1'b1; end
            ST_JUMP:   begin state_d = ST_FETCH; retire = 1'b1; end
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_RST_IDLE;
        endcase

        // Memory states only leave on ready or timeout, so any state change
        // (and any non-memory state) naturally restarts the wait count at 0.
        wait_d    = (is_mem_state(state_q) && !bus.mem_ready) ? wait_q + 8'd1 : 8'd0;
        retired_d = retired_q + CNT_W'(retire);
    end

    always_comb begin
        ctrl = '0;
        case (state_q)
            ST_FETCH: begin
                ctrl.i_or_d    = 1'b0;
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_a = SRC_A_PC;
                ctrl.alu_src_b = SRC_B_ONE;
                ctrl.alu_op    = ALU_ADD;
                if (bus.mem_ready) begin
                    ctrl.ir_write  = 1'b1;
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = PCSRC_ALU;
                end
            end
            ST_DECODE: begin
                // Speculative branch target PC + imm lands in ALUOut.
                ctrl.alu_src_a = SRC_A_PC;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            ST_EXEC: begin
                ctrl.alu_src_a = SRC_A_REG;
                ctrl.alu_src_b = cls.is_i ? SRC_B_IMM : SRC_B_REG;
                ctrl.alu_op    = cls_alu_op;
            end
            ST_ALU_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b0;
            end
            ST_ADDR: begin
                ctrl.alu_src_a = SRC_A_REG;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            ST_MEM_RD: begin
                ctrl.i_or_d   = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl.i_or_d    = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a = SRC_A_REG;
                ctrl.alu_src_b = SRC_B_REG;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_source = PCSRC_ALUOUT;
                ctrl.pc_write  = cls.is_bne ? !bus.zero : bus.zero;
            end
            ST_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            ST_HALT: ctrl.halted = 1'b1;
            default: ctrl = '0;
        endcase
    end

    assign bus.ir_write   = ctrl.ir_write;
    assign bus.pc_write   = ctrl.pc_write;
    assign bus.i_or_d     = ctrl.i_or_d;
    assign bus.mem_read   = ctrl.mem_read;
    assign bus.mem_write  = ctrl.mem_write;
    assign bus.reg_write  = ctrl.reg_write;
    assign bus.mem_to_reg = ctrl.mem_to_reg;
    assign bus.alu_src_a  = ctrl.alu_src_a;
    assign bus.alu_src_b  = ctrl.alu_src_b;
    assign bus.alu_op     = ctrl.alu_op;
    assign bus.pc_source  = ctrl.pc_source;
    assign bus.halted     = ctrl.halted;
    assign bus.illegal_op = illegal_q;
    assign bus.bus_error  = bus_err_q;
    assign bus.retired    = retired_q;

endmodule
